banco_reg: RTL and testbench
============================

// Module: banco_reg
// PURPOSE
//   MIPS general-purpose register file, 32 x 32-bit. Consumer of the write-register
//   select mux: WriteReg picks the destination (rt/rd/rs/$sp/$ra) and WriteData is the
//   write-back value. Two combinational read ports feed the A/B operand registers of
//   the multicycle datapath. A debug read port lets the testbench inspect any register.
// PARAMETERS
//   SP_RESET   227    reset value of r29 ($sp); all other registers reset to 0
//   BYPASS     0      1: a read of the register being written this cycle returns WriteData
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   RegWrite   in   1   write enable, sampled on rising clk
//   ReadReg1   in   5   read port 1 address (rs)
//   ReadReg2   in   5   read port 2 address (rt)
//   WriteReg   in   5   destination address from the write-register mux
//   WriteData  in   32  write-back data
//   ReadData1  out  32  contents of ReadReg1
//   ReadData2  out  32  contents of ReadReg2
//   DbgReg     in   5   debug read address
//   DbgData    out  32  contents of DbgReg (never bypassed)
//   WrDone     out  1   registered pulse: a write committed on the previous edge
// BEHAVIOUR
//   Reset (async, level): while reset=1, r0..r28, r30, r31 = 0; r29 = SP_RESET; WrDone = 0.
//     Takes effect immediately, without waiting for clk. Release is synchronous to
//     the next rising edge. No write commits on an edge where reset=1.
//   Write: on a rising clk with reset=0 and RegWrite=1, regs[WriteReg] <= WriteData.
//     If WriteReg=0, nothing is written. r0 reads 0 at all times.
//   WrDone: registered. Set to 1 on an edge where a write commits to a nonzero
//     register; otherwise cleared to 0. It is a one-cycle pulse per write.
//   Read: ReadData1/2 and DbgData are combinational, with zero-cycle latency from the
//     address. Address 0 returns 32'h0.
//   BYPASS=0: a read in the same cycle as a write to the same address returns the old
//     value. The new value is visible from the cycle after the edge.
//   BYPASS=1: if RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg, ReadDataN = WriteData
//     in that cycle. The bypass is inhibited while reset=1.
//   Ports are independent: both read ports and the debug port may address the same
//     register, including the one being written.
//   X/Z on WriteReg when RegWrite=0 has no effect. When RegWrite=1, WriteReg must be
//     known; the bench asserts this.
//   No state machine. The state is the 31 writable registers plus WrDone.
// TESTING
//   1 Assert reset mid-run, after r5 has been written -> DbgData(r29)=227 and DbgData(r5)=0
//     immediately, before the next clk edge; WrDone=0.
//   2 RegWrite=1, WriteReg=8, WriteData=32'hDEADBEEF, one edge -> ReadData1(8)=DEADBEEF next cycle.
//     WrDone=1 for exactly one cycle.
//   3 RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF -> ReadData2(0)=0; WrDone stays 0.
//   4 Same-cycle write r9=32'h12345678 with ReadReg1=9, r9 previously 32'h1:
//     BYPASS=0 -> ReadData1=1 before the edge; BYPASS=1 -> ReadData1=12345678 before the edge.
//   5 Write r31=32'h00400010 (JAL) and r29=226 ($sp decrement) on consecutive edges.
//     Then read both ports: ReadReg1=31, ReadReg2=29 -> 00400010 and 226.
//   6 RegWrite=0 with WriteReg=5'bx for 10 cycles -> all 32 registers unchanged (scan via DbgReg).

Source files
------------

// File: rtl/banco_reg.sv
// banco_reg: MIPS 32x32 register file, two async read ports, one debug port.
// Ports: clk, reset (async high), RegWrite/WriteReg/WriteData write side,
//   ReadReg1/2 -> ReadData1/2, DbgReg -> DbgData, WrDone write pulse.
module banco_reg #(
   parameter logic [31:0] SP_RESET = 32'd227,
   parameter bit          BYPASS   = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWrite,
   input  logic [4:0]  ReadReg1,
   input  logic [4:0]  ReadReg2,
   input  logic [4:0]  WriteReg,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2,
   input  logic [4:0]  DbgReg,
   output logic [31:0] DbgData,
   output logic        WrDone
);

   logic [31:0] regs [1:31];
   logic        wr_en;

   // r0 is never stored; a write to it is dropped entirely
   assign wr_en = RegWrite && (WriteReg != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= (i == 29) ? SP_RESET : 32'h0;
         end
         WrDone <= 1'b0;
      end else begin
         WrDone <= wr_en;
         if (wr_en) begin
            regs[WriteReg] <= WriteData;
         end
      end
   end

   function automatic logic [31:0] rd(input logic [4:0] a);
      rd = (a == 5'd0) ? 32'h0 : regs[a];
   endfunction

   // forwarding of the in-flight write; suppressed while reset holds
   logic hit1, hit2;
   assign hit1 = BYPASS && !reset && wr_en && (ReadReg1 == WriteReg);
   assign hit2 = BYPASS && !reset && wr_en && (ReadReg2 == WriteReg);

   assign ReadData1 = hit1 ? WriteData : rd(ReadReg1);
   assign ReadData2 = hit2 ? WriteData : rd(ReadReg2);
   assign DbgData   = rd(DbgReg);

endmodule

// File: tb/tb_banco_reg.sv
// tb_banco_reg: directed bench for banco_reg.
// Runs a BYPASS=0 and a BYPASS=1 instance side by side on shared inputs.
module tb_banco_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  ReadReg1, ReadReg2, WriteReg, DbgReg;
   logic [31:0] WriteData;
   logic [31:0] rd1_0, rd2_0, dbg_0, rd1_1, rd2_1, dbg_1;
   logic        wd_0, wd_1;

   int checks = 0;
   int errors = 0;
   logic [31:0] expr [32];

   always #5 clk = ~clk;

   banco_reg #(.SP_RESET(32'd227), .BYPASS(1'b0)) u0 (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .WriteReg(WriteReg), .WriteData(WriteData),
      .ReadData1(rd1_0), .ReadData2(rd2_0),
      .DbgReg(DbgReg), .DbgData(dbg_0), .WrDone(wd_0)
   );

   banco_reg #(.SP_RESET(32'd227), .BYPASS(1'b1)) u1 (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .WriteReg(WriteReg), .WriteData(WriteData),
      .ReadData1(rd1_1), .ReadData2(rd2_1),
      .DbgReg(DbgReg), .DbgData(dbg_1), .WrDone(wd_1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_model();
      for (int i = 0; i < 32; i++) expr[i] = (i == 29) ? 32'd227 : 32'h0;
   endtask

   // present a write for the coming edge and track it in the model
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      RegWrite = 1'b1;
      WriteReg = a;
      WriteData = d;
      step();
      if (a != 5'd0) expr[a] = d;
   endtask

   always @(posedge clk) begin
      if (RegWrite === 1'b1) begin
         checks++;
         assert (!$isunknown(WriteReg)) else begin
            errors++;
            $error("FAIL writereg_known observed=%b expected=known", WriteReg);
         end
      end
   end

   initial begin
      reset = 1'b1;
      RegWrite = 1'b0;
      ReadReg1 = 5'd0;
      ReadReg2 = 5'd0;
      WriteReg = 5'd0;
      WriteData = 32'h0;
      DbgReg = 5'd29;
      reset_model();
      #1;
      chk("rst_sp", dbg_0, 32'd227);
      chk("rst_wrdone", {31'h0, wd_0}, 32'h0);
      chk("rst_r0", rd1_0, 32'h0);
      step();
      reset = 1'b0;
      step();

      // writes then mid-cycle async reset
      wr(5'd5, 32'h55);
      DbgReg = 5'd5;
      #1;
      chk("wr_r5", dbg_0, 32'h55);
      chk("wr_r5_done", {31'h0, wd_0}, 32'h1);
      wr(5'd29, 32'h99);
      RegWrite = 1'b0;
      DbgReg = 5'd29;
      #1;
      chk("wr_r29", dbg_0, 32'h99);
      reset = 1'b1;
      reset_model();
      #1;
      chk("async_sp", dbg_0, 32'd227);
      chk("async_wrdone", {31'h0, wd_1}, 32'h0);
      DbgReg = 5'd5;
      #1;
      chk("async_r5", dbg_1, 32'h0);

      // no commit while reset holds
      RegWrite = 1'b1;
      WriteReg = 5'd7;
      WriteData = 32'h77;
      ReadReg1 = 5'd7;
      #1;
      chk("rst_nobypass", rd1_1, 32'h0);
      step();
      RegWrite = 1'b0;
      reset = 1'b0;
      DbgReg = 5'd7;
      #1;
      chk("rst_nowrite", dbg_0, 32'h0);
      step();

      // r8 write, one-cycle WrDone
      ReadReg1 = 5'd8;
      wr(5'd8, 32'hDEADBEEF);
      RegWrite = 1'b0;
      #1;
      chk("r8_p0", rd1_0, 32'hDEADBEEF);
      chk("r8_p1", rd1_1, 32'hDEADBEEF);
      chk("r8_done", {31'h0, wd_0}, 32'h1);
      step();
      chk("r8_done_off", {31'h0, wd_0}, 32'h0);

      // write to r0 is discarded
      ReadReg2 = 5'd0;
      RegWrite = 1'b1;
      WriteReg = 5'd0;
      WriteData = 32'hFFFFFFFF;
      #1;
      chk("r0_byp", rd2_1, 32'h0);
      step();
      RegWrite = 1'b0;
      chk("r0_rd", rd2_0, 32'h0);
      chk("r0_done", {31'h0, wd_1}, 32'h0);

      // same-cycle read of r9 during write
      wr(5'd9, 32'h1);
      RegWrite = 1'b1;
      WriteReg = 5'd9;
      WriteData = 32'h12345678;
      ReadReg1 = 5'd9;
      DbgReg = 5'd9;
      #1;
      chk("r9_old", rd1_0, 32'h1);
      chk("r9_byp", rd1_1, 32'h12345678);
      chk("r9_dbg", dbg_1, 32'h1);
      step();
      expr[9] = 32'h12345678;
      RegWrite = 1'b0;
      #1;
      chk("r9_new", rd1_0, 32'h12345678);

      // JAL link then $sp decrement
      wr(5'd31, 32'h00400010);
      wr(5'd29, 32'd226);
      RegWrite = 1'b0;
      ReadReg1 = 5'd31;
      ReadReg2 = 5'd29;
      #1;
      chk("ra_p0", rd1_0, 32'h00400010);
      chk("sp_p0", rd2_0, 32'd226);
      chk("ra_p1", rd1_1, 32'h00400010);
      chk("sp_p1", rd2_1, 32'd226);

      // idle with unknown WriteReg
      RegWrite = 1'b0;
      WriteReg = 5'bx;
      for (int i = 0; i < 10; i++) begin
         WriteData = $urandom;
         step();
      end
      for (int i = 0; i < 32; i++) begin
         DbgReg = 5'(i);
         #1;
         chk($sformatf("scan0_r%0d", i), dbg_0, expr[i]);
         chk($sformatf("scan1_r%0d", i), dbg_1, expr[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
